// File: rtl/midori_pkg.sv
// Shared widths and state encoding for the Midori-128 CTR stream controller.
package midori_pkg;

    localparam int BLOCK_W = 128;
    localparam int NONCE_W = 64;
    localparam int CTR_W   = 64;

    // Controller phases: waiting for data, waiting on the core, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } ctr_state_t;

endpackage

// File: rtl/midori_ctr_stream.sv
// Counter-mode stream controller feeding a fixed-latency Midori-128 core.
// One block is in flight at a time: accept, start the core, wait LATENCY
// cycles, XOR the keystream into the buffered block, hold until taken.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid, once raised, stays high with stable data until that transfer.
module midori_ctr_stream
    import midori_pkg::*;
#(
    parameter int LATENCY = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_text_in,
    input  logic [BLOCK_W-1:0] core_text_out,
    output logic               busy
);

    localparam int WCNT_W = $clog2(LATENCY + 1);
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(LATENCY);

    ctr_state_t         state_q;
    logic [NONCE_W-1:0] nonce_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [BLOCK_W-1:0] data_q;
    logic [WCNT_W-1:0]  wcnt;

    // A load pulse takes priority over data, so ready is withheld in that cycle.
    assign in_ready     = (state_q == IDLE) && !load;
    assign busy         = (state_q != IDLE);
    assign core_text_in = {nonce_q, ctr_q};

    // Sequencing of one block: capture, core wait, keystream XOR, output hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            nonce_q    <= '0;
            ctr_q      <= '0;
            data_q     <= '0;
            wcnt       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        nonce_q <= iv[BLOCK_W-1:CTR_W];
                        ctr_q   <= iv[CTR_W-1:0];
                    end else if (in_valid) begin
                        data_q     <= in_data;
                        wcnt       <= WCNT_INIT;
                        core_start <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    // The core output is valid exactly when the countdown hits zero;
                    // the counter advances on the same edge it is consumed.
                    if (wcnt == '0) begin
                        out_data  <= data_q ^ core_text_out;
                        out_valid <= 1'b1;
                        ctr_q     <= ctr_q + 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midori_ctr_stream.sv
// Self-checking bench for midori_ctr_stream with a fixed-latency core model.
module tb_midori_ctr_stream;
    import midori_pkg::*;

    localparam int LAT = 21;
    localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [127:0] iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         core_start;
    logic [127:0] core_text_in;
    logic [127:0] core_text_out;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: counter state and expected output queue
    logic [63:0]  exp_nonce = '0;
    logic [63:0]  exp_ctr = '0;
    logic [127:0] exp_q[$];

    midori_ctr_stream #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .load(load), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_text_in(core_text_in),
        .core_text_out(core_text_out), .busy(busy)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in keystream function for the core
    function automatic logic [127:0] ks_fn(input logic [127:0] t);
        return {t[63:0] ^ 64'h5A5A_C3C3_0F0F_9696, t[127:64] + 64'h0F1E_2D3C_4B5A_6978}
               ^ {t[95:0], t[127:96]};
    endfunction

    // Core model: keystream valid only once LAT cycles have elapsed since start
    logic [127:0] core_cap = '0;
    int           core_cnt = 1000;
    always @(posedge clk) begin
        if (core_start) begin
            core_cap <= core_text_in;
            core_cnt <= 1;
        end else if (core_cnt < 1000) begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign core_text_out = (core_cnt >= LAT) ? ks_fn(core_cap) : JUNK;

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [127:0] v);
        @(negedge clk);
        load = 1'b1;
        iv = v;
        @(negedge clk);
        load = 1'b0;
        exp_nonce = v[127:64];
        exp_ctr = v[63:0];
    endtask

    // Presents a block; returns at the negedge of the cycle after acceptance.
    task automatic accept(input logic [127:0] d, input bit keep, output int a_cyc, output bit ok);
        ok = 1'b0;
        a_cyc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                a_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            exp_q.push_back(d ^ ks_fn({exp_nonce, exp_ctr}));
            exp_ctr = exp_ctr + 64'd1;
        end
        @(negedge clk);
        if (!keep) in_valid = 1'b0;
    endtask

    // Waits for a result, stalls, then takes it; returns at the negedge after the handshake.
    task automatic collect(input int stall, output logic [127:0] d, output int v_cyc, output bit ok);
        ok = 1'b0;
        v_cyc = -1;
        d = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                v_cyc = cyc;
                d = out_data;
                break;
            end
        end
        if (ok) begin
            repeat (stall) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL reset_core_start: got %b want 0", core_start); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (core_text_in !== '0) begin n_err++; $display("FAIL reset_text_in: got %h want 0", core_text_in); end
        rst = 1'b0;
        exp_nonce = '0;
        exp_ctr = '0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_first_block();
        int a;
        bit ok;
        logic [127:0] e;
        do_load({64'h0123456789ABCDEF, 64'h0});
        n_cmp++; if (core_text_in !== 128'h0123456789ABCDEF_0000000000000000) begin
            n_err++; $display("FAIL first_text_in: got %h want 0123456789abcdef0000000000000000", core_text_in);
        end
        accept(128'h0, 1'b0, a, ok);
        n_cmp++; if (!ok || cyc != a + 1) begin n_err++; $display("FAIL first_accept: ok %b cyc %0d want %0d", ok, cyc, a + 1); end
        for (int k = 1; k <= LAT + 2; k++) begin
            n_cmp++; if (core_start !== (k == 1)) begin n_err++; $display("FAIL first_core_start@A+%0d: got %b", k, core_start); end
            n_cmp++; if (out_valid !== (k == LAT + 2)) begin n_err++; $display("FAIL first_out_valid@A+%0d: got %b", k, out_valid); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy@A+%0d: got %b want 1", k, busy); end
            if (k <= LAT + 1) begin
                n_cmp++; if (core_text_in !== 128'h0123456789ABCDEF_0000000000000000) begin
                    n_err++; $display("FAIL first_text_stable@A+%0d: got %h", k, core_text_in);
                end
            end
            if (k < LAT + 2) @(negedge clk);
        end
        n_cmp++; if (core_text_in !== 128'h0123456789ABCDEF_0000000000000001) begin
            n_err++; $display("FAIL first_ctr_inc: got %h want ...0001", core_text_in);
        end
        e = pop_exp();
        n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL first_out_data: got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL first_after_hs: in_ready %b busy %b out_valid %b want 1 0 0", in_ready, busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int a, v;
        bit ok, seen;
        logic [127:0] d1, d2, got, e;
        d1 = rand128();
        d2 = rand128();
        do_load({64'hFEED_FACE_CAFE_BABE, 64'h0});
        accept(d1, 1'b1, a, ok);
        in_data = d2;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_busy: got %b want 0", in_ready); end
            @(negedge clk);
        end
        e = pop_exp();
        n_cmp++; if (!seen || out_data !== e) begin n_err++; $display("FAIL b2b_data1: got %h want %h", out_data, e); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready_hold: got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready_after: got %b want 1", in_ready); end
        exp_q.push_back(d2 ^ ks_fn({exp_nonce, exp_ctr}));
        exp_ctr = exp_ctr + 64'd1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (core_start !== 1'b1 || core_text_in[63:0] !== 64'd1) begin
            n_err++; $display("FAIL b2b_second_start: core_start %b low %h want 1 1", core_start, core_text_in[63:0]);
        end
        collect(0, got, v, ok);
        e = pop_exp();
        n_cmp++; if (!ok || got !== e) begin n_err++; $display("FAIL b2b_data2: got %h want %h", got, e); end
    endtask

    task automatic test_hold_stall();
        int a;
        bit ok, seen;
        logic [127:0] d, e;
        accept(rand128(), 1'b0, a, ok);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        d = out_data;
        in_valid = 1'b1;
        in_data = rand128();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== d || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL stall_hold: valid %b data %h ready %b busy %b want 1 %h 0 1", out_valid, out_data, in_ready, busy, d);
            end
        end
        in_valid = 1'b0;
        e = pop_exp();
        n_cmp++; if (!seen || d !== e) begin n_err++; $display("FAIL stall_data: got %h want %h", d, e); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int a, v;
        bit ok;
        logic [63:0] nn;
        logic [127:0] got, e;
        nn = {$urandom(), $urandom()};
        do_load({nn, 64'hFFFF_FFFF_FFFF_FFFF});
        accept(rand128(), 1'b0, a, ok);
        collect($urandom_range(0, 3), got, v, ok);
        e = pop_exp();
        n_cmp++; if (!ok || got !== e) begin n_err++; $display("FAIL wrap_data1: got %h want %h", got, e); end
        accept(rand128(), 1'b0, a, ok);
        n_cmp++; if (core_text_in !== {nn, 64'h0}) begin n_err++; $display("FAIL wrap_text_in: got %h want %h", core_text_in, {nn, 64'h0}); end
        collect($urandom_range(0, 3), got, v, ok);
        e = pop_exp();
        n_cmp++; if (!ok || got !== e) begin n_err++; $display("FAIL wrap_data2: got %h want %h", got, e); end
    endtask

    task automatic test_load_mid_run();
        int a, v;
        bit ok;
        logic [127:0] ctx, got, e;
        ctx = rand128();
        do_load(ctx);
        accept(rand128(), 1'b0, a, ok);
        repeat (5) @(negedge clk);
        load = 1'b1;
        iv = rand128();
        @(negedge clk);
        load = 1'b0;
        n_cmp++; if (core_text_in !== ctx) begin n_err++; $display("FAIL midrun_load: got %h want %h", core_text_in, ctx); end
        collect(1, got, v, ok);
        e = pop_exp();
        n_cmp++; if (!ok || got !== e) begin n_err++; $display("FAIL midrun_data: got %h want %h", got, e); end
        n_cmp++; if (core_text_in !== {ctx[127:64], ctx[63:0] + 64'd1}) begin
            n_err++; $display("FAIL midrun_ctr: got %h want %h", core_text_in, {ctx[127:64], ctx[63:0] + 64'd1});
        end
    endtask

    task automatic test_load_and_valid();
        logic [127:0] x;
        x = rand128();
        @(negedge clk);
        load = 1'b1;
        iv = x;
        in_valid = 1'b1;
        in_data = rand128();
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lv_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        load = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (core_start !== 1'b0 || busy !== 1'b0 || core_text_in !== x) begin
            n_err++; $display("FAIL lv_no_start: start %b busy %b text %h want 0 0 %h", core_start, busy, core_text_in, x);
        end
        exp_nonce = x[127:64];
        exp_ctr = x[63:0];
    endtask

    task automatic test_reset_mid();
        int a;
        bit ok, stray;
        do_load(rand128());
        accept(rand128(), 1'b0, a, ok);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || core_start !== 1'b0 || out_valid !== 1'b0 || core_text_in !== '0) begin
            n_err++; $display("FAIL rstmid_async: busy %b start %b valid %b text %h want 0 0 0 0", busy, core_start, out_valid, core_text_in);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_nonce = '0;
        exp_ctr = '0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        n_cmp++; if (stray) begin n_err++; $display("FAIL rstmid_no_output: got out_valid 1 want 0"); end
        test_first_block();
    endtask

    task automatic test_random();
        int a, v;
        bit ok, ok2;
        logic [127:0] got, e;
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) do_load(rand128());
            accept(rand128(), 1'b0, a, ok);
            collect($urandom_range(0, 4), got, v, ok2);
            e = pop_exp();
            n_cmp++; if (!ok || !ok2 || got !== e) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", n, got, e); end
            n_cmp++; if (v != a + LAT + 2) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, v - a, LAT + 2); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_block();
        test_back_to_back();
        test_hold_stall();
        test_wrap();
        test_load_mid_run();
        test_load_and_valid();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
